clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Button-driven time-setting controller for the digital clock. It debounces the mode and increment buttons and sequences the clock through run, set-hour, set-minute and set-second states. It drives the run enable and single-cycle field-increment/clear pulses into the time counters, and a blink mask into the 7-segment scan so the field being edited flashes. Everything runs on the single fast system clock; no derived clocks.

## Interface
- DEB_CYCLES, 1000000: consecutive stable cycles required to accept a button level change.
- REPEAT_DELAY, 50000000: held cycles from press event to first auto-repeat pulse.
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses.
- BLINK_HALF, 25000000: cycles per blink half-period.
- TIMEOUT, 1000000000: idle cycles in a set state before automatic return to RUN.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
- btn_inc  in  1  raw increment button, active-high, asynchronous to clk.
- run_en  out  1  1 = time counters free-run; 0 = counting halted for setting.
- hour_inc  out  1  one-cycle pulse: hour field +1.
- min_inc  out  1  one-cycle pulse: minute field +1.
- sec_clr  out  1  one-cycle pulse: seconds cleared to 00.
- blink_mask  out  6  per-digit blank request to scan; [1:0] seconds, [3:2] minutes, [5:4] hours; 1 = blank.
- state  out  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.

## Operation
- Input conditioning per button: 2-flop synchronizer, then debounce counter; debounced level takes the synchronized value only after it differs from current debounced level for DEB_CYCLES consecutive cycles; any mismatch-break restarts the count. Press event = debounced 0->1, one cycle wide.
- FSM on mode press event: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- run_en = (state == RUN), decoded from the state register.
- RUN: inc presses ignored, no pulses, blink_mask = 0.
- SET_HOUR / SET_MIN: inc press event -> one pulse on hour_inc / min_inc. While debounced inc stays high: next pulse REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles until release.
- SET_SEC: inc press event -> one sec_clr pulse; no auto-repeat.
- Blink: counter restarted and phase = 0 on every state entry; phase toggles every BLINK_HALF cycles. Mask bits of the active field = phase; all other bits 0. Mask forced 0 while debounced inc is high.
- Timeout: idle counter cleared on state entry and on any press event (mode or inc); reaching TIMEOUT in a set state -> RUN. Holding inc counts as activity (counter held clear).
- Simultaneous mode and inc press events: mode wins, inc dropped. After any state change, repeat is disarmed until inc is released and pressed again.
- At most one of hour_inc, min_inc, sec_clr is high in any cycle.

## Timing
- Reset (synchronous): state = RUN, run_en = 1, all pulses 0, blink_mask = 0, debounced levels 0, all counters 0. Takes effect on the edge it is sampled; mid-debounce, mid-repeat or mid-set all abandon to RUN.
- Raw button first sampled high at edge E (stable thereafter): press event high in cycle following edge E+DEB_CYCLES+2. State change or field pulse registered one edge later (E+DEB_CYCLES+3).
- Auto-repeat pulse k (k≥1) occurs REPEAT_DELAY+(k-1)*REPEAT_PERIOD cycles after the press pulse.
- Timeout return to RUN occurs on the edge where the idle count reaches TIMEOUT; run_en rises on the same edge.
- Glitches shorter than DEB_CYCLES produce no event.

## Test plan
Bench parameters: DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, BLINK_HALF=8, TIMEOUT=100.
- Reset, then 4 clean mode presses -> state 1,2,3,0 in turn; run_en 0,0,0,1; each transition at E+7.
- SET_MIN, btn_inc held 40 cycles -> min_inc pulses at press P, P+20, P+25, P+30, P+35; hour_inc/sec_clr never; blink_mask 0 while held.
- SET_SEC, btn_inc held 40 cycles -> exactly one sec_clr pulse, no repeats.
- SET_HOUR, no activity -> blink_mask alternates 6'b110000/0 every 8 cycles; state returns to 0 after 100 idle cycles.
- btn_inc glitch high 3 cycles in SET_HOUR -> no hour_inc; mode and inc pressed same edge -> state advances, no inc pulse.
- Reset asserted mid auto-repeat in SET_MIN -> next edge: state 0, run_en 1, no further pulses.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// Button and status bundle between the time-setting controller and its surroundings.
// The master drives the raw buttons and observes status. The slave is the controller.
interface clock_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       run_en;
    logic       hour_inc;
    logic       min_inc;
    logic       sec_clr;
    logic [5:0] blink_mask;
    logic [1:0] state;

    modport master (
        output btn_mode, btn_inc,
        input  run_en, hour_inc, min_inc, sec_clr, blink_mask, state
    );

    modport slave (
        input  btn_mode, btn_inc,
        output run_en, hour_inc, min_inc, sec_clr, blink_mask, state
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the digital clock.
// It debounces the mode and inc buttons and steps through RUN, SET_HOUR, SET_MIN and SET_SEC.
// It emits single-cycle field pulses with auto-repeat, a blink mask for the edited field,
// and an idle timeout back to RUN.
module clock_set_ctrl #(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned BLINK_HALF    = 25000000,
    parameter int unsigned TIMEOUT       = 1000000000
) (
    input  logic            clk,
    input  logic            reset,
    clock_set_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_SET_HOUR = 2'd1,
        S_SET_MIN  = 2'd2,
        S_SET_SEC  = 2'd3
    } state_t;

    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned RW = $clog2(REP_MAX + 1);
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

    // Index 0 is the mode button. Index 1 is the inc button.
    logic [1:0]          raw;
    logic [1:0]          sync1, sync2;
    logic [1:0]          deb, deb_q;
    logic [1:0]          press;
    logic [1:0][DW-1:0]  deb_cnt;

    state_t              state_q, state_d;
    logic                entry;
    logic                mode_evt, inc_evt, deb_inc;
    logic                timeout_hit;

    logic                rep_armed_q, rep_first_q;
    logic [RW-1:0]       rep_cnt_q;
    logic [RW-1:0]       rep_limit;
    logic                rep_fire;

    logic                blink_phase_q;
    logic [BW-1:0]       blink_cnt_q;
    logic [TW-1:0]       idle_q;

    logic                hour_d, min_d, sec_d;
    logic                hour_q, min_q, sec_q;
    logic [5:0]          mask_d;

    assign raw      = {bus.btn_inc, bus.btn_mode};
    assign mode_evt = press[0];
    // Mode wins a simultaneous press, so the inc event is dropped.
    assign inc_evt  = press[1] & ~press[0];
    assign deb_inc  = deb[1];

    // Synchronize, debounce and edge-detect both buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            deb_q   <= '0;
            press   <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Compute the next state from mode presses and the idle timeout.
    always_comb begin
        state_d     = state_q;
        timeout_hit = (idle_q == TO_LAST) && !press[0] && !press[1] && !deb_inc;
        if (mode_evt) begin
            case (state_q)
                S_RUN:      state_d = S_SET_HOUR;
                S_SET_HOUR: state_d = S_SET_MIN;
                S_SET_MIN:  state_d = S_SET_SEC;
                default:    state_d = S_RUN;
            endcase
        end else if (state_q != S_RUN && timeout_hit) begin
            state_d = S_RUN;
        end
    end

    assign entry = (state_d != state_q);

    // Hold the state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // Decode the field pulses, the auto-repeat trigger and the blink mask.
    always_comb begin
        rep_limit = rep_first_q ? DELAY_LAST : PERIOD_LAST;
        rep_fire  = rep_armed_q && deb_inc && !entry && (rep_cnt_q == rep_limit);
        hour_d    = (state_q == S_SET_HOUR) && !entry && (inc_evt || rep_fire);
        min_d     = (state_q == S_SET_MIN)  && !entry && (inc_evt || rep_fire);
        sec_d     = (state_q == S_SET_SEC)  && !entry && inc_evt;
        mask_d    = '0;
        if (!deb_inc) begin
            case (state_q)
                S_SET_HOUR: mask_d[5:4] = {2{blink_phase_q}};
                S_SET_MIN:  mask_d[3:2] = {2{blink_phase_q}};
                S_SET_SEC:  mask_d[1:0] = {2{blink_phase_q}};
                default:    mask_d      = '0;
            endcase
        end
    end

    // Register the pulses and run the repeat, blink and idle counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hour_q        <= 1'b0;
            min_q         <= 1'b0;
            sec_q         <= 1'b0;
            rep_armed_q   <= 1'b0;
            rep_first_q   <= 1'b0;
            rep_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
            blink_cnt_q   <= '0;
            idle_q        <= '0;
        end else begin
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;

            // Any state change or release disarms the repeat; only a fresh press re-arms it.
            if (entry || !deb_inc) begin
                rep_armed_q <= 1'b0;
                rep_cnt_q   <= '0;
            end else if (inc_evt && (state_q == S_SET_HOUR || state_q == S_SET_MIN)) begin
                rep_armed_q <= 1'b1;
                rep_first_q <= 1'b1;
                rep_cnt_q   <= '0;
            end else if (rep_armed_q) begin
                if (rep_fire) begin
                    rep_first_q <= 1'b0;
                    rep_cnt_q   <= '0;
                end else begin
                    rep_cnt_q <= rep_cnt_q + RW'(1);
                end
            end

            if (entry) begin
                blink_phase_q <= 1'b0;
                blink_cnt_q   <= '0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_phase_q <= ~blink_phase_q;
                blink_cnt_q   <= '0;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end

            if (entry || press[0] || press[1] || deb_inc || state_q == S_RUN) idle_q <= '0;
            else                                                              idle_q <= idle_q + TW'(1);
        end
    end

    assign bus.run_en     = (state_q == S_RUN);
    assign bus.hour_inc   = hour_q;
    assign bus.min_inc    = min_q;
    assign bus.sec_clr    = sec_q;
    assign bus.blink_mask = mask_d;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl with small timing parameters.
module tb_clock_set_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .DEB_CYCLES    (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5),
        .BLINK_HALF    (8),
        .TIMEOUT       (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Generate the free-running system clock.
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean mode press and release without checks. The state changes 8 ticks after the press starts.
    task automatic mode_press();
        bus.btn_mode = 1'b1;
        tick(8);
        bus.btn_mode = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        total_cnt++;
        if (bus.state !== 2'd0) $display("FAIL reset_state got %0d exp 0", bus.state);
        else pass_cnt++;
        total_cnt++;
        if (bus.run_en !== 1'b1) $display("FAIL reset_run_en got %b exp 1", bus.run_en);
        else pass_cnt++;
        total_cnt++;
        if ({bus.hour_inc, bus.min_inc, bus.sec_clr} !== 3'b000)
            $display("FAIL reset_pulses got %b exp 000", {bus.hour_inc, bus.min_inc, bus.sec_clr});
        else pass_cnt++;
        total_cnt++;
        if (bus.blink_mask !== 6'd0) $display("FAIL reset_mask got %b exp 000000", bus.blink_mask);
        else pass_cnt++;
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_st [4];
        logic [1:0] prev;
        exp_st = '{2'd1, 2'd2, 2'd3, 2'd0};
        prev = 2'd0;
        for (int i = 0; i < 4; i++) begin
            bus.btn_mode = 1'b1;
            tick(7);
            total_cnt++;
            if (bus.state !== prev) $display("FAIL mode_early[%0d] got %0d exp %0d", i, bus.state, prev);
            else pass_cnt++;
            tick(1);
            total_cnt++;
            if (bus.state !== exp_st[i]) $display("FAIL mode_state[%0d] got %0d exp %0d", i, bus.state, exp_st[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus.run_en !== (exp_st[i] == 2'd0))
                $display("FAIL mode_run_en[%0d] got %b exp %b", i, bus.run_en, exp_st[i] == 2'd0);
            else pass_cnt++;
            bus.btn_mode = 1'b0;
            tick(8);
            prev = exp_st[i];
        end
    endtask

    task automatic test_min_repeat();
        logic exp_p;
        mode_press();
        mode_press();
        total_cnt++;
        if (bus.state !== 2'd2) $display("FAIL min_enter got %0d exp 2", bus.state);
        else pass_cnt++;
        bus.btn_inc = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 40) bus.btn_inc = 1'b0;
            tick(1);
            exp_p = (i == 7) || (i == 27) || (i == 32) || (i == 37) || (i == 42);
            total_cnt++;
            if (bus.min_inc !== exp_p) $display("FAIL min_rep_pulse[%0d] got %b exp %b", i, bus.min_inc, exp_p);
            else pass_cnt++;
            total_cnt++;
            if ((bus.hour_inc | bus.sec_clr) !== 1'b0)
                $display("FAIL min_rep_other[%0d] got %b exp 0", i, bus.hour_inc | bus.sec_clr);
            else pass_cnt++;
            if (i >= 6 && i <= 44) begin
                total_cnt++;
                if (bus.blink_mask !== 6'd0) $display("FAIL min_rep_mask[%0d] got %b exp 000000", i, bus.blink_mask);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_sec_clr();
        mode_press();
        total_cnt++;
        if (bus.state !== 2'd3) $display("FAIL sec_enter got %0d exp 3", bus.state);
        else pass_cnt++;
        bus.btn_inc = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 40) bus.btn_inc = 1'b0;
            tick(1);
            total_cnt++;
            if (bus.sec_clr !== (i == 7)) $display("FAIL sec_pulse[%0d] got %b exp %b", i, bus.sec_clr, i == 7);
            else pass_cnt++;
            total_cnt++;
            if ((bus.hour_inc | bus.min_inc) !== 1'b0)
                $display("FAIL sec_other[%0d] got %b exp 0", i, bus.hour_inc | bus.min_inc);
            else pass_cnt++;
        end
        mode_press();
        total_cnt++;
        if (bus.state !== 2'd0) $display("FAIL sec_exit got %0d exp 0", bus.state);
        else pass_cnt++;
    endtask

    task automatic test_blink_timeout();
        logic [5:0] exp_m;
        logic [1:0] exp_s;
        bus.btn_mode = 1'b1;
        tick(8);
        bus.btn_mode = 1'b0;
        // Now just past the SET_HOUR entry edge (k = 0).
        for (int k = 0; k <= 100; k++) begin
            exp_s = (k < 100) ? 2'd1 : 2'd0;
            exp_m = (k < 100 && ((k / 8) % 2) == 1) ? 6'b110000 : 6'b000000;
            total_cnt++;
            if (bus.state !== exp_s) $display("FAIL blink_state[%0d] got %0d exp %0d", k, bus.state, exp_s);
            else pass_cnt++;
            total_cnt++;
            if (bus.blink_mask !== exp_m) $display("FAIL blink_mask[%0d] got %b exp %b", k, bus.blink_mask, exp_m);
            else pass_cnt++;
            if (k < 100) tick(1);
        end
        total_cnt++;
        if (bus.run_en !== 1'b1) $display("FAIL timeout_run_en got %b exp 1", bus.run_en);
        else pass_cnt++;
        tick(10);
    endtask

    task automatic test_glitch_and_simul();
        mode_press();
        bus.btn_inc = 1'b1;
        tick(3);
        bus.btn_inc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            total_cnt++;
            if (bus.hour_inc !== 1'b0) $display("FAIL glitch_hour[%0d] got %b exp 0", i, bus.hour_inc);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.state !== 2'd1) $display("FAIL glitch_state got %0d exp 1", bus.state);
        else pass_cnt++;
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            total_cnt++;
            if ({bus.hour_inc, bus.min_inc, bus.sec_clr} !== 3'b000)
                $display("FAIL simul_pulses[%0d] got %b exp 000", i, {bus.hour_inc, bus.min_inc, bus.sec_clr});
            else pass_cnt++;
            if (i == 7) begin
                total_cnt++;
                if (bus.state !== 2'd2) $display("FAIL simul_state got %0d exp 2", bus.state);
                else pass_cnt++;
            end
        end
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        tick(10);
        mode_press();
        mode_press();
        total_cnt++;
        if (bus.state !== 2'd0) $display("FAIL simul_exit got %0d exp 0", bus.state);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_repeat();
        mode_press();
        mode_press();
        bus.btn_inc = 1'b1;
        tick(30);
        reset = 1'b1;
        tick(1);
        total_cnt++;
        if (bus.state !== 2'd0) $display("FAIL rst_mid_state got %0d exp 0", bus.state);
        else pass_cnt++;
        total_cnt++;
        if (bus.run_en !== 1'b1) $display("FAIL rst_mid_run_en got %b exp 1", bus.run_en);
        else pass_cnt++;
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            total_cnt++;
            if ({bus.hour_inc, bus.min_inc, bus.sec_clr} !== 3'b000)
                $display("FAIL rst_mid_pulses[%0d] got %b exp 000", i, {bus.hour_inc, bus.min_inc, bus.sec_clr});
            else pass_cnt++;
            total_cnt++;
            if (bus.state !== 2'd0) $display("FAIL rst_mid_hold[%0d] got %0d exp 0", i, bus.state);
            else pass_cnt++;
        end
        bus.btn_inc = 1'b0;
        tick(10);
    endtask

    // Run the directed scenarios in sequence.
    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        test_reset();
        test_mode_cycle();
        test_min_repeat();
        test_sec_clr();
        test_blink_timeout();
        test_glitch_and_simul();
        test_reset_mid_repeat();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
